e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
Multiply/divide unit in the Execute stage. It sits directly downstream of the D/E pipeline register and consumes instr_e, rs_e and rt_e. It decodes MDU instructions, runs multi-cycle mult/multu/div/divu, and holds the architectural HI/LO registers. It supplies start/busy to the hazard unit and HI/LO read data to the E-stage result mux.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
instr_e  in  32  instruction held in E (from D/E register)
rs_e  in  32  forwarded rs operand
rt_e  in  32  forwarded rt operand
start  out  1  combinational; high when instr_e is mult/multu/div/divu and state is IDLE
busy  out  1  registered; high while an operation is in flight
hi  out  32  architectural HI
lo  out  32  architectural LO
mdu_rd  out  32  combinational; hi when instr_e is mfhi, lo when mflo, else 0

Behaviour:
- Decode: opcode 6'h00, with funct 18 mult, 19 multu, 1A div, 1B divu, 10 mfhi, 11 mthi, 12 mflo, 13 mtlo (hex).
- States:
  - IDLE: no operation in flight.
  - BUSY: a mult/div is counting down.
- Reset: state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending result regs=0.
- IDLE with start=1:
  - At the posedge, compute the 64-bit result and latch it into pending_hi/pending_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy=1.
- BUSY:
  - cnt decrements each cycle.
  - At the posedge where cnt==1: hi/lo take pending values, busy=0, state=IDLE.
- Timeline: start in cycle 0; busy high in cycles 1..N; new hi/lo visible from cycle N+1.
- Hazard contract: the hazard unit stalls any MDU instruction (including mfhi/mflo/mthi/mtlo) in D while start|busy. The D/E clear therefore delivers NOPs (0x00000000) to this block while busy.
- MDU instruction in E while BUSY: ignored (no start, no HI/LO write). The bench flags it as a protocol violation.
- mthi/mtlo: in IDLE, hi (or lo) takes rs_e at the posedge. In BUSY they are ignored.
- Arithmetic:
  - mult: signed 32x32 to 64-bit product, HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div/divu: LO=quotient, HI=remainder. Truncation is toward zero; the remainder takes the dividend's sign.
- Divide by zero (both div and divu): LO=32'hFFFFFFFF, HI=rs_e.
- Signed overflow (div of 32'h80000000 by 32'hFFFFFFFF): LO=32'h80000000, HI=0.
- Operands are sampled only in the start cycle. Later changes to rs_e/rt_e have no effect.
- rst mid-operation: the operation is abandoned, state=IDLE, and hi/lo=0 on the next cycle.
- mdu_rd reflects committed hi/lo only. Pending values are never forwarded.

Decomposition:
- Shared package mips_pkg:
  - Opcode/funct localparams (FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO, OP_SPECIAL).
  - State encoding (MDU_IDLE, MDU_BUSY).
- One natural sub-module: mdu_arith. It is purely combinational: inputs are op select, rs and rt; outputs are 64-bit {hi, lo}, including the divide-by-zero and overflow rules.
- e_mdu holds the FSM, counter, pending registers and HI/LO.

Test Plan:
1. Reset then idle: rst high 2 cycles -> hi=0, lo=0, busy=0, start=0; NOP instr_e keeps them unchanged.
2. mult with rs=32'hFFFFFFFF, rt=2:
   - start=1 in cycle 0; busy=1 in cycles 1..5.
   - From cycle 6: hi=32'hFFFFFFFF, lo=32'hFFFFFFFE.
   - mfhi in E at cycle 6 gives mdu_rd=32'hFFFFFFFF.
3. multu with rs=32'hFFFFFFFF, rt=2 -> after 5 busy cycles, hi=1, lo=32'hFFFFFFFE.
4. div with rs=-7 (32'hFFFFFFF9), rt=2:
   - busy for 10 cycles.
   - Then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
   - Change rs_e/rt_e during busy -> no effect on the result.
5. Corner divides:
   - divu 7/0 -> lo=32'hFFFFFFFF, hi=7.
   - div 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
6. mthi/mtlo and reset:
   - mthi rs=32'h1234 while IDLE -> hi=32'h1234 next cycle.
   - mtlo presented while busy -> lo unchanged.
   - rst asserted at busy cycle 3 -> busy=0, hi=lo=0, and no late commit.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and MDU type definitions for the E stage.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  typedef enum logic [1:0] {
    MDU_OP_MULT  = 2'd0,
    MDU_OP_MULTU = 2'd1,
    MDU_OP_DIV   = 2'd2,
    MDU_OP_DIVU  = 2'd3
  } mdu_op_e;

  function automatic logic [31:0] mk_special(input logic [5:0] funct);
    return {OP_SPECIAL, 20'd0, funct};
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational MDU datapath: 64-bit {hi, lo} for mult/multu/div/divu,
// including the divide-by-zero and signed-overflow results.
module mdu_arith
  import mips_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Low 64 bits of the sign-extended product equal the signed product.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Sign-magnitude division: truncates toward zero and gives the remainder
  // the dividend's sign. 0x80000000 / -1 naturally yields q=0x80000000, r=0.
  assign signed_div = (op == MDU_OP_DIV);
  assign a_neg      = signed_div & rs[31];
  assign b_neg      = signed_div & rt[31];
  assign a_mag      = a_neg ? (32'd0 - rs) : rs;
  assign b_mag      = b_neg ? (32'd0 - rt) : rt;
  assign b_safe     = (rt == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    result = 64'd0;
    case (op)
      MDU_OP_MULT:  result = prod_s;
      MDU_OP_MULTU: result = prod_u;
      MDU_OP_DIV,
      MDU_OP_DIVU: begin
        if (rt == 32'd0) result = {rs, 32'hFFFF_FFFF};
        else             result = {rem, quot};
      end
      default:      result = 64'd0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: decodes MDU instructions, runs a
// fixed-latency mult/div countdown and owns the architectural HI/LO registers.
module e_mdu
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_rd
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  mdu_state_e  state;
  mdu_state_e  state_d;
  logic [3:0]  cnt;
  logic [3:0]  cnt_d;
  logic [31:0] pending_hi;
  logic [31:0] pending_lo;
  logic        load;
  logic        commit;

  logic        is_special;
  logic [5:0]  funct;
  logic        is_md_op;
  mdu_op_e     op;
  logic        is_mfhi;
  logic        is_mflo;
  logic        is_mthi;
  logic        is_mtlo;
  logic [63:0] arith_res;
  logic        unused_instr_bits;

  assign is_special        = (instr_e[31:26] == OP_SPECIAL);
  assign funct             = instr_e[5:0];
  assign unused_instr_bits = ^instr_e[25:6];

  always_comb begin
    is_md_op = 1'b0;
    op       = MDU_OP_MULT;
    if (is_special) begin
      case (funct)
        FUNCT_MULT:  begin is_md_op = 1'b1; op = MDU_OP_MULT;  end
        FUNCT_MULTU: begin is_md_op = 1'b1; op = MDU_OP_MULTU; end
        FUNCT_DIV:   begin is_md_op = 1'b1; op = MDU_OP_DIV;   end
        FUNCT_DIVU:  begin is_md_op = 1'b1; op = MDU_OP_DIVU;  end
        default:     begin is_md_op = 1'b0; op = MDU_OP_MULT;  end
      endcase
    end
  end

  assign is_mfhi = is_special && (funct == FUNCT_MFHI);
  assign is_mflo = is_special && (funct == FUNCT_MFLO);
  assign is_mthi = is_special && (funct == FUNCT_MTHI);
  assign is_mtlo = is_special && (funct == FUNCT_MTLO);

  mdu_arith u_arith (
    .op     (op),
    .rs     (rs_e),
    .rt     (rt_e),
    .result (arith_res)
  );

  // Hazard handshake: start is a one-cycle request accepted unconditionally
  // in IDLE; busy stays high until hi/lo are committed, and the hazard unit
  // must hold every MDU instruction out of E while start|busy is high.
  assign start = is_md_op && (state == MDU_IDLE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    commit  = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (start) begin
          state_d = MDU_BUSY;
          load    = 1'b1;
          cnt_d   = (op == MDU_OP_MULT || op == MDU_OP_MULTU) ? MULT_LOAD : DIV_LOAD;
        end
      end
      MDU_BUSY: begin
        if (cnt == 4'd1) begin
          state_d = MDU_IDLE;
          commit  = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      busy  <= (state_d == MDU_BUSY);
    end
  end

  // Operands are captured only here; later rs_e/rt_e changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
    end else if (load) begin
      pending_hi <= arith_res[63:32];
      pending_lo <= arith_res[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (commit) begin
      hi <= pending_hi;
      lo <= pending_lo;
    end else if (state == MDU_IDLE) begin
      if (is_mthi) hi <= rs_e;
      if (is_mtlo) lo <= rs_e;
    end
  end

  always_comb begin
    mdu_rd = 32'd0;
    if (is_mfhi)      mdu_rd = hi;
    else if (is_mflo) mdu_rd = lo;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: vector table of mult/div cases plus hand-written
// sequences for mthi/mtlo, busy-time writes and mid-operation reset.
module tb_e_mdu;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] instr_e;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_rd;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  e_mdu #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .instr_e (instr_e),
    .rs_e    (rs_e),
    .rt_e    (rt_e),
    .start   (start),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .mdu_rd  (mdu_rd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  function automatic logic is_mdu_instr(input logic [31:0] ins);
    return (ins[31:26] == OP_SPECIAL) &&
           (ins[5:0] inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                             FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO});
  endfunction

  always @(posedge clk) begin
    if (!rst && busy && is_mdu_instr(instr_e))
      $display("protocol violation: MDU instruction %h in E while busy", instr_e);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver: issue one mult/div from IDLE, scramble operands while busy,
  // then compare the committed result and the mfhi/mflo read path
  task automatic run_op(input vec_t v);
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    int          busy_cnt;
    exp_q.push_back(v.exp_hi);
    exp_q.push_back(v.exp_lo);
    @(negedge clk);
    prev_hi = hi;
    prev_lo = lo;
    instr_e = mk_special(v.funct);
    rs_e    = v.rs;
    rt_e    = v.rt;
    #1;
    check({v.name, " start"}, {31'd0, start}, 32'd1);
    @(negedge clk);
    instr_e  = 32'd0;
    busy_cnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cnt++;
      check({v.name, " hi held"}, hi, prev_hi);
      check({v.name, " lo held"}, lo, prev_lo);
      rs_e = $urandom;
      rt_e = $urandom;
      @(negedge clk);
    end
    check({v.name, " busy cycles"}, 32'(busy_cnt), 32'(v.cycles));
    e_hi = exp_q.pop_front();
    e_lo = exp_q.pop_front();
    check({v.name, " hi"}, hi, e_hi);
    check({v.name, " lo"}, lo, e_lo);
    instr_e = mk_special(FUNCT_MFHI);
    #1;
    check({v.name, " mfhi"}, mdu_rd, e_hi);
    instr_e = mk_special(FUNCT_MFLO);
    #1;
    check({v.name, " mflo"}, mdu_rd, e_lo);
    instr_e = 32'd0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{"mult_neg",    FUNCT_MULT,  32'hFFFF_FFFF, 32'd2,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{"multu_big",   FUNCT_MULTU, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{"div_neg",     FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_zero",   FUNCT_DIVU,  32'd7,         32'd0,         10, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{"div_ovf",     FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{"mult_max",    FUNCT_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 5,  32'h3FFF_FFFF, 32'h0000_0001};
    vecs[6] = '{"multu_msb",   FUNCT_MULTU, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{"div_negdiv",  FUNCT_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{"divu_plain",  FUNCT_DIVU,  32'd100,       32'd7,         10, 32'h0000_0002, 32'h0000_000E};
    vecs[9] = '{"div_zero",    FUNCT_DIV,   32'h8000_0000, 32'd0,         10, 32'h8000_0000, 32'hFFFF_FFFF};

    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    instr_e = 32'd0;
    rs_e    = 32'd0;
    rt_e    = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset start", {31'd0, start}, 32'd0);
    rs_e = 32'hA5A5_A5A5;
    repeat (3) @(negedge clk);
    check("nop hi", hi, 32'd0);
    check("nop lo", lo, 32'd0);
    check("nop busy", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 10; k++) run_op(vecs[k]);

    // mthi / mtlo while idle
    @(negedge clk);
    instr_e = mk_special(FUNCT_MTHI);
    rs_e    = 32'h0000_1234;
    #1;
    check("mthi start", {31'd0, start}, 32'd0);
    @(negedge clk);
    instr_e = mk_special(FUNCT_MTLO);
    rs_e    = 32'h0000_5678;
    #1;
    check("mthi hi", hi, 32'h0000_1234);
    @(negedge clk);
    instr_e = 32'd0;
    check("mtlo lo", lo, 32'h0000_5678);
    check("mtlo hi kept", hi, 32'h0000_1234);

    // mtlo and a second mult while busy are both ignored
    @(negedge clk);
    instr_e = mk_special(FUNCT_MULT);
    rs_e    = 32'h0001_0000;
    rt_e    = 32'h0001_0003;
    @(negedge clk);
    instr_e = mk_special(FUNCT_MTLO);
    rs_e    = 32'hDEAD_BEEF;
    #1;
    check("busy mtlo start", {31'd0, start}, 32'd0);
    @(negedge clk);
    check("busy mtlo lo", lo, 32'h0000_5678);
    instr_e = mk_special(FUNCT_MULT);
    #1;
    check("busy mult start", {31'd0, start}, 32'd0);
    @(negedge clk);
    instr_e = 32'd0;
    wait_idle("mult_after_mtlo");
    check("mult_after_mtlo hi", hi, 32'h0000_0001);
    check("mult_after_mtlo lo", lo, 32'h0003_0000);

    // reset during busy cycle 3 abandons the divide
    @(negedge clk);
    instr_e = mk_special(FUNCT_DIVU);
    rs_e    = 32'd1000;
    rt_e    = 32'd3;
    @(negedge clk);
    instr_e = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check("pre-rst busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("no late commit busy", {31'd0, busy}, 32'd0);
    check("no late commit hi", hi, 32'd0);
    check("no late commit lo", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
